// File: rtl/drr_queue_manager.sv
// rtl/drr_queue_manager.sv - per-queue descriptor store feeding a DRR scheduler
// Circular buffer per queue; a granted head is popped into a valid/ready tx stage.
module drr_queue_manager #(
  parameter int PKT_QS_CNT = 4,
  parameter int DESC_DEPTH = 8,
  parameter int SIZE_W     = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             enq_i,
  input  logic [$clog2(PKT_QS_CNT)-1:0]    enq_qid_i,
  input  logic [SIZE_W-1:0]                enq_size_i,
  output logic                             enq_ready_o,
  input  logic [PKT_QS_CNT-1:0]            flush_i,
  output logic [PKT_QS_CNT-1:0][15:0]      size_o,
  output logic [PKT_QS_CNT-1:0]            size_val_o,
  output logic                             ready_o,
  input  logic [$clog2(PKT_QS_CNT)-1:0]    cng_addr_i,
  input  logic                             cng_val_i,
  output logic [$clog2(PKT_QS_CNT)-1:0]    tx_qid_o,
  output logic [SIZE_W-1:0]                tx_size_o,
  output logic                             tx_val_o,
  input  logic                             tx_ready_i,
  output logic [PKT_QS_CNT-1:0]            full_o,
  output logic [15:0]                      drop_cnt_o,
  output logic                             grant_err_o
);
  localparam int QW = $clog2(PKT_QS_CNT);
  localparam int PW = $clog2(DESC_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state;
  logic [SIZE_W-1:0] mem    [PKT_QS_CNT][DESC_DEPTH];
  logic [PW-1:0]     rd_ptr [PKT_QS_CNT];
  logic [PW-1:0]     wr_ptr [PKT_QS_CNT];
  logic [CW-1:0]     count  [PKT_QS_CNT];

  logic enq_ok;
  logic enq_drop;
  logic grant_ok;

  always_comb begin
    for (int q = 0; q < PKT_QS_CNT; q++) begin
      full_o[q]     = (count[q] == CW'(DESC_DEPTH));
      size_val_o[q] = (count[q] != '0);
      size_o[q]     = size_val_o[q] ? mem[q][rd_ptr[q]] : '0;
    end
  end

  assign enq_ready_o = !full_o[enq_qid_i];
  assign ready_o     = !tx_val_o || tx_ready_i;

  // A flushed queue swallows its enqueue silently; only full/zero-size drops count.
  assign enq_ok   = enq_i && !full_o[enq_qid_i] && (enq_size_i != '0) && !flush_i[enq_qid_i];
  assign enq_drop = enq_i && !flush_i[enq_qid_i] && (full_o[enq_qid_i] || (enq_size_i == '0));
  assign grant_ok = cng_val_i && ready_o && size_val_o[cng_addr_i] && !flush_i[cng_addr_i];

  always_ff @(posedge clk_i) begin
    if (enq_ok) mem[enq_qid_i][wr_ptr[enq_qid_i]] <= enq_size_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int q = 0; q < PKT_QS_CNT; q++) begin
        rd_ptr[q] <= '0;
        wr_ptr[q] <= '0;
        count[q]  <= '0;
      end
    end else begin
      for (int q = 0; q < PKT_QS_CNT; q++) begin
        if (flush_i[q]) begin
          rd_ptr[q] <= '0;
          wr_ptr[q] <= '0;
          count[q]  <= '0;
        end else begin
          logic push;
          logic pop;
          push = enq_ok && (enq_qid_i == QW'(q));
          pop  = grant_ok && (cng_addr_i == QW'(q));
          if (push) wr_ptr[q] <= wr_ptr[q] + 1'b1;
          if (pop)  rd_ptr[q] <= rd_ptr[q] + 1'b1;
          count[q] <= count[q] + CW'(push) - CW'(pop);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      tx_val_o    <= 1'b0;
      tx_qid_o    <= '0;
      tx_size_o   <= '0;
      grant_err_o <= 1'b0;
      drop_cnt_o  <= '0;
    end else begin
      grant_err_o <= cng_val_i && !grant_ok;
      if (enq_drop && (drop_cnt_o != 16'hFFFF)) drop_cnt_o <= drop_cnt_o + 16'd1;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            state     <= HOLD;
            tx_val_o  <= 1'b1;
            tx_qid_o  <= cng_addr_i;
            tx_size_o <= size_o[cng_addr_i];
          end
        end
        HOLD: begin
          if (grant_ok) begin
            tx_qid_o  <= cng_addr_i;
            tx_size_o <= size_o[cng_addr_i];
          end else if (tx_ready_i) begin
            state    <= IDLE;
            tx_val_o <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tx_val_o <= 1'b0;
        end
      endcase
    end
  end
endmodule
